// File: rtl/pixel_unpacker_pkg.sv
// Shared constants and types for the pixel unpacker: frame geometry defaults,
// sticky error bit positions and the sync state encoding.
package pixel_unpacker_pkg;

  localparam int unsigned X_SIZE_DFLT = 1280;
  localparam int unsigned Y_SIZE_DFLT = 720;

  localparam int unsigned ERR_TLAST = 0;
  localparam int unsigned ERR_TUSER = 1;
  localparam int unsigned ERR_TKEEP = 2;
  localparam int unsigned ERR_W     = 3;

  typedef enum logic {
    IDLE   = 1'b0,
    SYNCED = 1'b1
  } sync_state_e;

  function automatic int unsigned words_per_line(input int unsigned x_size);
    return x_size * 3 / 4;
  endfunction

endpackage

// File: rtl/pixel_unpacker_byte_realigner.sv
// 48-bit byte FIFO for the unpacker: 32-bit words append above the resident
// bytes, 24-bit pixels shift out from the bottom.
module byte_realigner (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        clear_i,
  input  logic        append_i,
  input  logic        shift_i,
  input  logic [31:0] word_i,
  output logic [23:0] head_o,
  output logic [2:0]  cnt_o
);

  logic [47:0] data_q, data_d;
  logic [2:0]  cnt_q, cnt_d;

  // Bytes above cnt are kept zero, so an append can OR the new word in place.
  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      data_d = {16'h0000, word_i};
      cnt_d  = 3'd4;
    end else if (clear_i) begin
      data_d = '0;
      cnt_d  = '0;
    end else begin
      if (shift_i) begin
        data_d = {24'h000000, data_q[47:24]};
        cnt_d  = cnt_q - 3'd3;
      end
      if (append_i) begin
        data_d = data_d | ({16'h0000, word_i} << {cnt_d, 3'b000});
        cnt_d  = cnt_d + 3'd4;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head_o = data_q[23:0];
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/pixel_unpacker.sv
// AXI4-Stream sink that unpacks densely packed 24-bit RGB from 32-bit words
// into one pixel per handshake, tagging sof/eol/eof and flagging framing errors.
module pixel_unpacker
  import pixel_unpacker_pkg::*;
#(
  parameter int unsigned X_SIZE = X_SIZE_DFLT,
  parameter int unsigned Y_SIZE = Y_SIZE_DFLT
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [31:0]      in_stream_tdata,
  input  logic [3:0]       in_stream_tkeep,
  input  logic             in_stream_tlast,
  input  logic             in_stream_tuser,
  input  logic             in_stream_tvalid,
  output logic             in_stream_tready,
  output logic [7:0]       r,
  output logic [7:0]       g,
  output logic [7:0]       b,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic             sof,
  output logic             eol,
  output logic             eof,
  output logic [ERR_W-1:0] err,
  input  logic             err_clear
);

  localparam int unsigned WORDS_PER_LINE = words_per_line(X_SIZE);
  localparam int unsigned XW = $clog2(X_SIZE + 1);
  localparam int unsigned YW = $clog2(Y_SIZE + 1);
  localparam int unsigned WW = $clog2(WORDS_PER_LINE + 1);
  localparam logic [XW-1:0] X_LAST = XW'(X_SIZE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(Y_SIZE - 1);
  localparam logic [WW-1:0] W_LAST = WW'(WORDS_PER_LINE - 1);

  sync_state_e      state_q, state_d;
  logic [XW-1:0]    x_q, x_d, x_post;
  logic [YW-1:0]    y_q, y_d, y_post;
  logic [WW-1:0]    wcnt_q, wcnt_d, wcnt_cur;
  logic [ERR_W-1:0] err_q, err_d;

  logic [23:0] head;
  logic [2:0]  cnt;
  logic [2:0]  residual;
  logic        synced, emit, acc, frame_end, last_exp;
  logic        load, clear, append, consume;

  assign synced           = (state_q == SYNCED);
  assign pix_valid        = synced && (cnt >= 3'd3);
  assign emit             = pix_valid && pix_ready;
  assign in_stream_tready = aresetn && ((cnt <= 3'd2) || ((cnt <= 3'd5) && emit));
  assign acc              = in_stream_tvalid && in_stream_tready;

  byte_realigner u_realigner (
    .clk_i    (aclk),
    .rst_ni   (aresetn),
    .load_i   (load),
    .clear_i  (clear),
    .append_i (append),
    .shift_i  (emit),
    .word_i   (in_stream_tdata),
    .head_o   (head),
    .cnt_o    (cnt)
  );

  always_comb begin
    x_post    = x_q;
    y_post    = y_q;
    frame_end = 1'b0;
    if (emit) begin
      if (x_q == X_LAST) begin
        x_post = '0;
        if (y_q == Y_LAST) begin
          y_post    = '0;
          frame_end = 1'b1;
        end else begin
          y_post = y_q + 1'b1;
        end
      end else begin
        x_post = x_q + 1'b1;
      end
    end
    residual = cnt - (emit ? 3'd3 : 3'd0);
  end

  // The tuser check uses post-emit state so a next-frame tuser word accepted
  // alongside the final pixel of the previous frame is not an error.
  always_comb begin
    state_d  = state_q;
    x_d      = x_post;
    y_d      = y_post;
    wcnt_d   = wcnt_q;
    wcnt_cur = wcnt_q;
    err_d    = err_clear ? '0 : err_q;
    load     = 1'b0;
    clear    = 1'b0;
    append   = 1'b0;
    consume  = 1'b0;
    last_exp = 1'b0;

    if (acc && in_stream_tuser) begin
      load     = 1'b1;
      consume  = 1'b1;
      state_d  = SYNCED;
      x_d      = '0;
      y_d      = '0;
      wcnt_cur = '0;
      if (synced && ((residual != 3'd0) || (x_post != '0) || (y_post != '0)))
        err_d[ERR_TUSER] = 1'b1;
    end else if (synced && frame_end) begin
      state_d = IDLE;
      clear   = 1'b1;
      wcnt_d  = '0;
    end else if (synced) begin
      append  = acc;
      consume = acc;
    end

    if (consume) begin
      last_exp = (wcnt_cur == W_LAST);
      if (in_stream_tlast != last_exp)
        err_d[ERR_TLAST] = 1'b1;
      if (in_stream_tkeep != 4'hF)
        err_d[ERR_TKEEP] = 1'b1;
      wcnt_d = last_exp ? '0 : wcnt_cur + 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      wcnt_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
    end
  end

  assign b   = head[7:0];
  assign g   = head[15:8];
  assign r   = head[23:16];
  assign sof = pix_valid && (x_q == '0) && (y_q == '0);
  assign eol = pix_valid && (x_q == X_LAST);
  assign eof = eol && (y_q == Y_LAST);
  assign err = err_q;

endmodule

// File: doc/pixel_unpacker.md
Name: pixel_unpacker

Overview:
- AXI4-Stream video sink: the receive-side counterpart of the pixel packer. Accepts 32-bit words carrying densely packed 24-bit RGB pixels and unpacks them into one pixel per handshake, with sof/eol/eof tags.
- Sits between the VDMA MM2S stream and the grid-initialisation / line-buffer logic. Frames written by the host can then be loaded into BRAM without going through the register file.
- Checks framing and reports sticky error flags.

Parameters:
- X_SIZE, 1280, pixels per line; must be a multiple of 4.
- Y_SIZE, 720, lines per frame.
- WORDS_PER_LINE, X_SIZE*3/4 (localparam), stream words per line; 960 at default.

Ports:
- aclk  in  1  single clock for all logic.
- aresetn  in  1  asynchronous active-low reset.
- in_stream_tdata  in  32  packed pixel bytes, little-endian byte order.
- in_stream_tkeep  in  4  must be 4'hF.
- in_stream_tlast  in  1  last word of a line.
- in_stream_tuser  in  1  first word of a frame.
- in_stream_tvalid  in  1  word valid.
- in_stream_tready  out  1  word accepted when tvalid&&tready.
- r, g, b  out  8 each  head pixel.
- pix_valid  out  1  head pixel valid.
- pix_ready  in  1  consumer accepts the pixel when pix_valid&&pix_ready.
- sof  out  1  head pixel is x=0, y=0.
- eol  out  1  head pixel is x=X_SIZE-1.
- eof  out  1  eol && y=Y_SIZE-1.
- err  out  3  sticky flags: [0] tlast misaligned, [1] tuser mid-stream, [2] tkeep != 4'hF.
- err_clear  in  1  synchronous clear of err.

Behaviour:
- Byte stream: bytes B0,B1,... taken from each word at [7:0],[15:8],[23:16],[31:24].
- Pixel assembly: pixel Pk = {B(3k+2), B(3k+1), B(3k)} = {r,g,b}, i.e. b is the lowest byte.
- Buffer: 48-bit byte buffer plus byte count cnt, range 0..6. The head pixel is the lowest 3 bytes.
- pix_valid = (cnt>=3) && synced. r, g, b, sof, eol, eof are driven only from registered state.
- emit = pix_valid && pix_ready.
- in_stream_tready = aresetn && (cnt<=2 || (cnt<=5 && emit)). This gives full rate: 4 pixels per 4 cycles, 3 words per 4 cycles, in steady state.
- cnt update: cnt' = cnt + 4*acc - 3*emit. On simultaneous accept and emit, the emitted bytes shift out and the new word appends above the remaining bytes.
- Latency: word accepted in cycle N gives its first pixel at pix_valid in cycle N+1.
- Sync FSM, state IDLE:
  - After reset the block is in IDLE.
  - Words are accepted (tready=1) and discarded.
  - A word with tuser=1 is loaded, x, y and wcnt are cleared, and the FSM moves to SYNCED.
- Sync FSM, state SYNCED: normal unpacking.
  - A word with tuser=1 while cnt!=0 or x!=0 or y!=0 sets err[1].
  - The buffer is then flushed: residual bytes are dropped, the new word is loaded at byte 0, and x=y=wcnt=0.
- Pixel counters on emit:
  - x increments; at X_SIZE-1 it wraps to 0 and y increments.
  - y wraps to 0 after Y_SIZE-1; the next frame then expects tuser.
- Word counter wcnt: 0..WORDS_PER_LINE-1, incremented on each accepted word, wraps to 0 at the end of a line.
  - tlast=1 with wcnt!=WORDS_PER_LINE-1, or tlast=0 with wcnt==WORDS_PER_LINE-1: set err[0]. No realignment; recovery only via tuser.
- tkeep != 4'hF on an accepted word sets err[2]. The word is still consumed as 4 bytes.
- err bits are sticky.
  - err_clear clears all bits.
  - An error event in the same cycle as err_clear wins: the bit stays set.
- Reset values: cnt=0, state IDLE, x=y=wcnt=0, err=0.
  - Outputs: pix_valid=0, sof=eol=eof=0, r=g=b=0, in_stream_tready=0 while aresetn is low.
- Reset mid-frame: all state is cleared immediately. Re-synchronisation requires a new tuser word.
- pix_ready low: the head pixel and tags are held stable. tready follows the cnt rule, so backpressure propagates once cnt>2.

Decomposition:
- Shared package holds:
  - X_SIZE, Y_SIZE;
  - the err bit indices (ERR_TLAST=0, ERR_TUSER=1, ERR_TKEEP=2);
  - the sync state encoding (IDLE, SYNCED).
- Sub-module byte_realigner: the 48-bit buffer and cnt with append/shift. The top level holds the FSM, counters and checks.

Test Plan:
- Basic unpack: after reset send tuser word 0x44332211, then 0x88776655, then 0xCCBBAA99, with pix_ready=1.
  - Pixels are {r,g,b} = 332211 (sof=1), then 665544, 998877, CCBBAA.
  - First pix_valid appears one cycle after the first accept.
- Full frame at X_SIZE=8, Y_SIZE=2: 6 words/line with tlast on words 5 and 11, tvalid and pix_ready held high.
  - 16 pixels; eol at x=7.
  - eof on pixel 15; err=0.
  - Steady-state throughput is 1 pixel/cycle.
- Backpressure: pix_ready low for 10 cycles mid-line.
  - cnt saturates at 3..6 and tready falls.
  - Head pixel is stable; no byte loss after resume.
- Pre-sync discard: 3 words without tuser, then a tuser frame.
  - No pix_valid before the tuser word.
  - First pixel is taken from the tuser word.
- Framing errors: tlast on word 3 of a 6-word line → err=3'b001. Then tuser mid-line → err=3'b011 and buffer flushed, next pixel = bytes [23:0] of the tuser word. Then tkeep=4'h7 → err=3'b111. Then err_clear → err=0.
- Async reset mid-line with cnt=5.
  - Outputs go to 0 immediately, tready=0 while reset is held.
  - After release the block returns to IDLE.
